rx_block_lock_ctrl: RTL and testbench



---
 rtl/rx_block_lock_ctrl.sv | 128 ++++++++++++
 tb/tb_rx_block_lock_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_lock_ctrl.sv
// Block lock controller for the 10GBASE-R receive PCS.
// Walks block_sync alignment via slip pulses until sync headers are stable.
module rx_block_lock_ctrl #(
    parameter int HDR_WIDTH      = 2,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32,
    parameter int SLIP_CNT_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [HDR_WIDTH-1:0]      i_sync_hdr,
    input  logic                      i_hdr_valid,
    output logic                      o_slip,
    output logic                      o_block_lock,
    output logic [SLIP_CNT_WIDTH-1:0] o_slip_count
);
    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
    localparam logic [SH_W-1:0]   SH_ONE    = SH_W'(1);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
    localparam logic [INV_W-1:0]  INV_ONE   = INV_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [SLIP_CNT_WIDTH-1:0] SLIP_SAT = '1;
    localparam logic [SLIP_CNT_WIDTH-1:0] SLIP_ONE = SLIP_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        TEST_SH,
        SLIP,
        WAIT
    } state_t;

    state_t              state, state_n;
    logic [SH_W-1:0]     sh_cnt, sh_cnt_n, sh_inc;
    logic [INV_W-1:0]    inv_cnt, inv_cnt_n, inv_inc;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
    logic                lock_n;
    logic                hdr_ok;

    assign hdr_ok = (i_sync_hdr == HDR_WIDTH'(1)) ||
                    (i_sync_hdr == HDR_WIDTH'(2));

    always_comb begin
        state_n    = state;
        sh_cnt_n   = sh_cnt;
        inv_cnt_n  = inv_cnt;
        wait_cnt_n = wait_cnt;
        lock_n     = o_block_lock;
        sh_inc     = sh_cnt + SH_ONE;
        inv_inc    = hdr_ok ? inv_cnt : inv_cnt + INV_ONE;

        unique case (state)
            TEST_SH: begin
                if (i_hdr_valid) begin
                    sh_cnt_n  = sh_inc;
                    inv_cnt_n = inv_inc;
                    if (!o_block_lock) begin
                        // an invalid header wins over a completed window
                        if (!hdr_ok) begin
                            state_n   = SLIP;
                            sh_cnt_n  = '0;
                            inv_cnt_n = '0;
                        end else if (sh_inc == SH_LAST && inv_inc == '0) begin
                            lock_n    = 1'b1;
                            sh_cnt_n  = '0;
                            inv_cnt_n = '0;
                        end
                    end else begin
                        if (inv_inc == INV_LAST) begin
                            lock_n    = 1'b0;
                            state_n   = SLIP;
                            sh_cnt_n  = '0;
                            inv_cnt_n = '0;
                        end else if (sh_inc == SH_LAST) begin
                            sh_cnt_n  = '0;
                            inv_cnt_n = '0;
                        end
                    end
                end
            end
            SLIP: begin
                state_n    = WAIT;
                wait_cnt_n = '0;
            end
            WAIT: begin
                // block_sync realigns here, so headers are not trusted
                if (wait_cnt == WAIT_LAST) begin
                    state_n    = TEST_SH;
                    wait_cnt_n = '0;
                    sh_cnt_n   = '0;
                    inv_cnt_n  = '0;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                state_n = TEST_SH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= TEST_SH;
            sh_cnt       <= '0;
            inv_cnt      <= '0;
            wait_cnt     <= '0;
            o_slip       <= 1'b0;
            o_block_lock <= 1'b0;
            o_slip_count <= '0;
        end else begin
            state        <= state_n;
            sh_cnt       <= sh_cnt_n;
            inv_cnt      <= inv_cnt_n;
            wait_cnt     <= wait_cnt_n;
            o_block_lock <= lock_n;
            o_slip       <= (state_n == SLIP);
            if (state_n == SLIP && o_slip_count != SLIP_SAT) begin
                o_slip_count <= o_slip_count + SLIP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
// Scoreboard bench for rx_block_lock_ctrl: stimulus queues expected
// lock/slip events and snapshots, a negedge monitor pops and compares.
module tb_rx_block_lock_ctrl;
    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_SLIP = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int   cyc;
        logic lock;
        logic slip;
        int   cnt;
    } snap_t;

    logic       i_clk;
    logic       i_reset;
    logic [1:0] i_sync_hdr;
    logic       i_hdr_valid;
    logic       o_slip;
    logic       o_block_lock;
    logic [7:0] o_slip_count;

    ev_t   ev_q[$];
    snap_t snap_q[$];

    int   ne;
    int   last;
    int   compared;
    int   mismatched;
    bit   started;
    logic prev_lock;

    rx_block_lock_ctrl dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_sync_hdr   (i_sync_hdr),
        .i_hdr_valid  (i_hdr_valid),
        .o_slip       (o_slip),
        .o_block_lock (o_block_lock),
        .o_slip_count (o_slip_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial ne = 0;
    always @(posedge i_clk) ne <= ne + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, ne=%0d", ne);
        $fatal(1);
    end

    task automatic push_ev(input int kind, input int cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        ev_q.push_back(e);
    endtask

    task automatic push_snap(input int cyc, input logic lock, input int cnt);
        snap_t s;
        s.cyc  = cyc;
        s.lock = lock;
        s.slip = 1'b0;
        s.cnt  = cnt;
        snap_q.push_back(s);
    endtask

    task automatic snap(input logic lock, input int cnt);
        push_snap(last + 1, lock, cnt);
    endtask

    task automatic drive(input logic v, input logic [1:0] h);
        @(negedge i_clk);
        i_reset     = 1'b0;
        i_hdr_valid = v;
        i_sync_hdr  = h;
        last        = ne;
    endtask

    task automatic do_reset(input bit was_locked);
        @(negedge i_clk);
        i_reset     = 1'b1;
        i_hdr_valid = 1'b0;
        i_sync_hdr  = 2'b01;
        last        = ne;
        if (was_locked) push_ev(EV_FALL, last + 1);
        push_snap(last + 1, 1'b0, 0);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        compared++;
        if (ev_q.size() == 0) begin
            mismatched++;
            $display("FAIL event: got kind=%0d at cyc=%0d, required none",
                     kind, ne);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.cyc != ne) begin
                mismatched++;
                $display("FAIL event: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                         kind, ne, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (started) begin
            if (o_block_lock !== prev_lock)
                check_ev(o_block_lock ? EV_RISE : EV_FALL);
            if (o_slip !== 1'b0)
                check_ev(EV_SLIP);
            prev_lock = o_block_lock;
            while (snap_q.size() != 0 && snap_q[0].cyc <= ne) begin
                snap_t s;
                s = snap_q.pop_front();
                compared++;
                if (s.cyc != ne || o_block_lock !== s.lock ||
                    o_slip !== s.slip || o_slip_count !== 8'(s.cnt)) begin
                    mismatched++;
                    $display("FAIL snap@%0d: got lock=%b slip=%b cnt=%0d, required lock=%b slip=%b cnt=%0d (at %0d)",
                             ne, o_block_lock, o_slip, o_slip_count,
                             s.lock, s.slip, s.cnt, s.cyc);
                end
            end
        end
    end

    initial begin
        int n0;
        compared    = 0;
        mismatched  = 0;
        started     = 0;
        prev_lock   = 1'b0;
        i_reset     = 1'b1;
        i_hdr_valid = 1'b0;
        i_sync_hdr  = 2'b00;
        repeat (3) @(negedge i_clk);
        started = 1;
        last    = ne;
        push_snap(last + 1, 1'b0, 0);

        // 1: 64 good headers on alternate cycles give lock
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, 2'b01);
            if (i == 63) snap(1'b0, 0);
            if (i == 64) push_ev(EV_RISE, last + 1);
            drive(1'b0, 2'b01);
        end
        snap(1'b1, 0);

        // 2: unlocked, 10th header bad; 33 bad headers ignored in WAIT
        do_reset(1'b1);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, (i == 10) ? 2'b11 : 2'b01);
        end
        push_ev(EV_SLIP, last + 1);
        repeat (33) drive(1'b1, 2'b11);
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, 2'b01);
            if (i == 63) snap(1'b0, 1);
            if (i == 64) push_ev(EV_RISE, last + 1);
        end
        drive(1'b0, 2'b01);
        snap(1'b1, 1);

        // 3: 15 bad in a window holds lock; 16 bad in next loses it
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, (i % 4 == 0 && i <= 60) ? 2'b00 : 2'b01);
        end
        snap(1'b1, 1);
        for (int i = 1; i <= 48; i++) begin
            drive(1'b1, (i % 3 == 0) ? 2'b00 : 2'b01);
        end
        push_ev(EV_FALL, last + 1);
        push_ev(EV_SLIP, last + 1);
        repeat (33) drive(1'b0, 2'b01);
        snap(1'b0, 2);
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, 2'b10);
            if (i == 64) push_ev(EV_RISE, last + 1);
        end

        // 4: 15 bad then 64th bad: 16th invalid beats window end
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, (i <= 15 || i == 64) ? 2'b00 : 2'b01);
            if (i == 63) snap(1'b1, 2);
        end
        push_ev(EV_FALL, last + 1);
        push_ev(EV_SLIP, last + 1);
        repeat (3) drive(1'b0, 2'b01);

        // 5: reset in WAIT discards pending slip
        do_reset(1'b0);
        repeat (40) drive(1'b1, 2'b01);
        snap(1'b0, 0);
        drive(1'b1, 2'b11);
        push_ev(EV_SLIP, last + 1);
        repeat (33) drive(1'b0, 2'b01);
        snap(1'b0, 1);

        // 6: constant bad headers, 300 slips 34 cycles apart, count saturates
        do_reset(1'b0);
        drive(1'b1, 2'b11);
        n0 = last;
        for (int k = 0; k < 300; k++) push_ev(EV_SLIP, n0 + 1 + 34 * k);
        push_snap(n0 + 6, 1'b0, 1);
        push_snap(n0 + 6 + 34 * 9, 1'b0, 10);
        push_snap(n0 + 6 + 34 * 253, 1'b0, 254);
        push_snap(n0 + 6 + 34 * 254, 1'b0, 255);
        push_snap(n0 + 6 + 34 * 255, 1'b0, 255);
        push_snap(n0 + 6 + 34 * 299, 1'b0, 255);
        repeat (34 * 299 + 3) drive(1'b1, 2'b11);
        repeat (8) drive(1'b0, 2'b01);

        while (ev_q.size() != 0) begin
            ev_t e;
            e = ev_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL event: got nothing, required kind=%0d cyc=%0d",
                     e.kind, e.cyc);
        end
        while (snap_q.size() != 0) begin
            snap_t s;
            s = snap_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL snap: got nothing, required check at cyc=%0d", s.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
